// File: rtl/rr_stream_mux_pkg.sv
// rtl/rr_stream_mux_pkg.sv - shared types and constants for the round-robin stream mux
package rr_stream_mux_pkg;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mode_e;

    localparam int STALL_CNT_W = 16;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic [SEL_W-1:0]  gnt_idx,
    output logic              gnt_vld
);

    int idx;

    // Walk the channels from ptr upward with wrap; the first requester wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        idx     = 0;
        for (int off = 0; off < NUM_CH; off++) begin
            idx = (int'(ptr) + off) % NUM_CH;
            if (!gnt_vld && req[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
    end

endmodule

// File: rtl/rr_stream_mux.sv
// rtl/rr_stream_mux.sv - N-channel registered stream mux, fixed or round-robin select; RR_STREAM_MUX_STALL_CNT_EN adds a stall counter
module rr_stream_mux
    import rr_stream_mux_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
`ifdef RR_STREAM_MUX_STALL_CNT_EN
    ,
    input  logic                     clr_stall,
    output logic [STALL_CNT_W-1:0]   stall_cnt
`endif
);

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_ch_q,    out_ch_d;
    logic [SEL_W-1:0]  rr_ptr_q,    rr_ptr_d;

    logic [SEL_W-1:0]  arb_idx;
    logic              arb_vld;
    logic [SEL_W-1:0]  grant;
    logic              grant_vld;
    logic              load;
    logic              take;
    logic [DATA_W-1:0] grant_data;

    rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req     (in_valid),
        .ptr     (rr_ptr_q),
        .gnt_idx (arb_idx),
        .gnt_vld (arb_vld)
    );

    // Grant selection, ready generation and data mux; ready is held low in reset so nothing is accepted.
    always_comb begin
        if (mode_e'(mode) == MODE_RR) begin
            grant     = arb_idx;
            grant_vld = arb_vld;
        end else begin
            grant     = sel;
            grant_vld = ({1'b0, sel} < (SEL_W+1)'(NUM_CH)) && in_valid[sel];
        end
        load       = !out_valid_q || out_ready;
        take       = rst_n && load && grant_vld;
        in_ready   = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant == SEL_W'(i)) begin
                in_ready[i] = take;
                grant_data  = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next state of the output register and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        rr_ptr_d    = rr_ptr_q;
        if (take) begin
            out_valid_d = 1'b1;
            out_data_d  = grant_data;
            out_ch_d    = grant;
            if (mode_e'(mode) == MODE_RR) begin
                rr_ptr_d = (grant == SEL_W'(NUM_CH-1)) ? '0 : grant + 1'b1;
            end
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Output stage and pointer registers; reset drops any held beat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

`ifdef RR_STREAM_MUX_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where a held beat is refused; clear beats increment, value saturates.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (clr_stall) begin
            stall_cnt_d = '0;
        end else if (out_valid_q && !out_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rr_stream_mux.sv
// tb/tb_rr_stream_mux.sv - randomized and directed bench for rr_stream_mux against a behavioural model
module tb_rr_stream_mux;

    localparam int NUM_CH = 4;
    localparam int DATA_W = 8;
    localparam int SEL_W  = 2;

    logic                     clk = 1'b0;
    logic                     rst_n;
    logic                     mode;
    logic [SEL_W-1:0]         sel;
    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         out_ch;
    logic                     out_ready;
`ifdef RR_STREAM_MUX_STALL_CNT_EN
    logic                     clr_stall;
    logic [15:0]              stall_cnt;
`endif

    rr_stream_mux #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef RR_STREAM_MUX_STALL_CNT_EN
        ,
        .clr_stall (clr_stall),
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // behavioural model state
    int         m_ptr;
    logic       m_ov;
    logic [7:0] m_od;
    int         m_oc;
    int         m_stall;
    int         acc;
    logic [3:0] seen_rdy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // channel that the spec's grant rules pick, or -1 when nothing is granted
    function automatic int pick(input logic md, input int s, input logic [3:0] v);
        if (md == 1'b0) begin
            if (s < NUM_CH && v[s]) return s;
            return -1;
        end
        for (int k = 0; k < NUM_CH; k++) begin
            int c;
            c = (m_ptr + k) % NUM_CH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    task automatic cycle(input logic r, input logic md, input int s, input logic [3:0] v,
                         input logic [31:0] d, input logic ordy, input logic clr);
        int   g;
        logic ld;
        logic [3:0] er;
        @(negedge clk);
        rst_n = r; mode = md; sel = SEL_W'(s); in_valid = v; in_data = d; out_ready = ordy;
`ifdef RR_STREAM_MUX_STALL_CNT_EN
        clr_stall = clr;
`endif
        #1;
        g  = pick(md, s, v);
        ld = !m_ov || ordy;
        er = (r && ld && g >= 0) ? 4'(1 << g) : 4'b0000;
        seen_rdy = in_ready;
        check("in_ready", 32'(in_ready), 32'(er));
        check("out_valid", 32'(out_valid), 32'(m_ov));
        check("out_data", 32'(out_data), 32'(m_od));
        check("out_ch", 32'(out_ch), m_oc);
`ifdef RR_STREAM_MUX_STALL_CNT_EN
        check("stall_cnt", 32'(stall_cnt), m_stall);
`endif
        @(posedge clk);
        acc = -1;
        if (!r) begin
            m_ov = 1'b0; m_od = 8'h00; m_oc = 0; m_ptr = 0; m_stall = 0;
        end else begin
            if (clr) m_stall = 0;
            else if (m_ov && !ordy && m_stall != 16'hFFFF) m_stall++;
            if (ld && g >= 0) begin
                m_ov = 1'b1;
                m_od = d[g*8 +: 8];
                m_oc = g;
                if (md) m_ptr = (g + 1) % NUM_CH;
                acc = g;
            end else if (ordy) begin
                m_ov = 1'b0;
            end
        end
    endtask

    logic [3:0] ch_v;
    logic [7:0] ch_d [NUM_CH];
    logic       r_md;
    int         r_sel;

    initial begin
        m_ptr = 0; m_ov = 0; m_od = 0; m_oc = 0; m_stall = 0; acc = -1;
        rst_n = 0; mode = 0; sel = 0; in_valid = 0; in_data = 0; out_ready = 0;
`ifdef RR_STREAM_MUX_STALL_CNT_EN
        clr_stall = 0;
`endif

        // reset holds everything quiet even with all channels requesting
        cycle(0, 1, 0, 4'b1111, 32'h44332211, 1, 0);
        cycle(0, 1, 0, 4'b1111, 32'h44332211, 1, 0);
        check("rst_ready", 32'(seen_rdy), 0);
        // first RR beat after reset comes from ch0; then fairness 0,1,2,3,0,1,2,3
        for (int k = 0; k < 8; k++) begin
            cycle(1, 1, 0, 4'b1111, 32'h44332211, 1, 0);
            #1 check("rr_seq", 32'(out_ch), k % 4);
        end

        // fixed select of ch2
        cycle(0, 0, 0, 4'b0000, 0, 1, 0);
        cycle(1, 0, 2, 4'b0100, 32'h00A50000, 1, 0);
        check("fix_ready", 32'(seen_rdy), 32'h4);
        #1 check("fix_data", 32'(out_data), 32'hA5);
        check("fix_ch", 32'(out_ch), 2);
        cycle(1, 0, 1, 4'b0100, 32'h00A50000, 1, 0);
        check("fix_nogrant", 32'(seen_rdy), 0);

        // skip and wrap
        cycle(0, 1, 0, 4'b0000, 0, 1, 0);
        for (int k = 0; k < 4; k++) begin
            cycle(1, 1, 0, 4'b1001, 32'h77000066, 1, 0);
            #1 check("wrap_seq", 32'(out_ch), (k % 2 == 0) ? 0 : 3);
        end

        // backpressure with ch1 held
        cycle(0, 1, 0, 4'b0000, 0, 1, 0);
        cycle(1, 1, 0, 4'b0010, 32'h00003C00, 1, 0);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 1, 0, 4'b1111, 32'h44332211, 0, 0);
            check("bp_ready", 32'(seen_rdy), 0);
            #1 check("bp_data", 32'(out_data), 32'h3C);
        end
        cycle(1, 1, 0, 4'b1111, 32'h44332211, 1, 0);
        check("bp_release", 32'(seen_rdy), 32'h4);
        #1 check("bp_next_ch", 32'(out_ch), 2);
        check("bp_next_data", 32'(out_data), 32'h33);

`ifdef RR_STREAM_MUX_STALL_CNT_EN
        cycle(0, 1, 0, 4'b0000, 0, 1, 0);
        cycle(1, 1, 0, 4'b0001, 32'h000000AA, 1, 0);
        for (int k = 0; k < 5; k++) cycle(1, 1, 0, 4'b0000, 0, 0, 0);
        #1 check("stall_5", 32'(stall_cnt), 5);
        cycle(1, 1, 0, 4'b0000, 0, 0, 1);
        #1 check("stall_clr", 32'(stall_cnt), 0);
        for (int k = 0; k < 65540; k++) cycle(1, 1, 0, 4'b0000, 0, 0, 0);
        #1 check("stall_sat", 32'(stall_cnt), 32'hFFFF);
`endif

        // randomized traffic with held producers, mode/sel changes and a mid-run reset
        cycle(0, 1, 0, 4'b0000, 0, 1, 0);
        ch_v = 4'b0000;
        for (int c = 0; c < NUM_CH; c++) ch_d[c] = 8'h00;
        r_md = 1'b1; r_sel = 0;
        for (int n = 0; n < 600; n++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (!ch_v[c]) begin
                    ch_v[c] = ($urandom_range(0, 2) != 0);
                    ch_d[c] = 8'($urandom);
                end
            end
            if ($urandom_range(0, 15) == 0) r_md = ~r_md;
            if ($urandom_range(0, 7) == 0) r_sel = $urandom_range(0, NUM_CH-1);
            cycle((n % 250) != 137, r_md, r_sel, ch_v,
                  {ch_d[3], ch_d[2], ch_d[1], ch_d[0]},
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 31) == 0));
            if (acc >= 0) ch_v[acc] = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
